// File: rtl/ddr4_cmd_sequencer.sv
// DDR4 command sequencer: per-bank open-row tracking, ACT/PRE/RD/WR timing.
// Periodic refresh (PREA/REF) is compiled in only with `define REFRESH_EN.
module ddr4_cmd_sequencer #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int TRP       = 4,
    parameter int TRCD      = 4,
    parameter int TCCD      = 4,
    parameter int TREFI     = 7800,
    parameter int TRFC      = 88
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 ref_busy,
    output logic                 rw_issued
);

    localparam int IW   = BGWIDTH + BAWIDTH;
    localparam int NB   = 1 << IW;
    localparam int TM1  = (TRP > TRCD) ? TRP : TRCD;
    localparam int TM2  = (TM1 > TCCD) ? TM1 : TCCD;
    localparam int TM3  = (TM2 > TRFC) ? TM2 : TRFC;
    localparam int TMAX = (TM3 > TREFI) ? TM3 : TREFI;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] L_TRP  = TW'(TRP - 1);
    localparam logic [TW-1:0] L_TRCD = TW'(TRCD - 1);
    localparam logic [TW-1:0] L_TCCD = TW'(TCCD - 1);
    localparam logic [TW-1:0] L_TRFC = TW'(TRFC - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_PRE_WAIT,
        S_ACT,
        S_ACT_WAIT,
        S_RW,
        S_RW_WAIT,
        S_REF_PREA,
        S_REF_RP_WAIT,
        S_REF,
        S_REF_WAIT
    } state_t;

    state_t                 r_state;
    state_t                 w_nxt;
    logic [TW-1:0]          r_cnt;
    logic [TW-1:0]          w_cnt_nxt;
    logic                   r_cke;
    logic                   r_rdy_en;

    logic                   r_we;
    logic [BGWIDTH-1:0]     r_bg;
    logic [BAWIDTH-1:0]     r_ba;
    logic [ADDRWIDTH-1:0]   r_row;
    logic [COLWIDTH-1:0]    r_col;

    logic [NB-1:0]          r_valid;
    logic [ADDRWIDTH-1:0]   r_rows [NB];

    logic                   r_cs_n;
    logic                   r_act_n;
    logic [ADDRWIDTH-1:0]   r_a;
    logic [BGWIDTH-1:0]     r_bg_o;
    logic [BAWIDTH-1:0]     r_ba_o;
    logic                   r_rw_issued;

    logic                   w_ready;
    logic                   w_hs;
    logic                   w_ref_pend;
    logic                   w_we;
    logic [BGWIDTH-1:0]     w_bg;
    logic [BAWIDTH-1:0]     w_ba;
    logic [ADDRWIDTH-1:0]   w_row;
    logic [COLWIDTH-1:0]    w_col;
    logic [IW-1:0]          w_req_idx;
    logic [IW-1:0]          w_idx;
    logic                   w_open;
    logic                   w_hit;
    logic                   w_any_open;

    logic                   w_cs_n;
    logic                   w_act_n;
    logic [ADDRWIDTH-1:0]   w_a;
    logic [BGWIDTH-1:0]     w_bg_o;
    logic [BAWIDTH-1:0]     w_ba_o;

`ifdef REFRESH_EN
    localparam logic [TW-1:0] L_TREFI = TW'(TREFI - 1);

    logic [TW-1:0] r_refi;
    logic          r_ref_pend;
    logic          w_refi_exp;
    logic          w_ref_go;

    assign w_refi_exp = (r_refi == L_TREFI);
    assign w_ref_go   = (r_state == S_IDLE) && r_rdy_en && r_ref_pend;

    // Pending is a single flag, so an expiry while already pending merges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_refi     <= '0;
            r_ref_pend <= 1'b0;
        end else begin
            r_refi     <= w_refi_exp ? '0 : r_refi + TW'(1);
            r_ref_pend <= w_refi_exp | (r_ref_pend & ~w_ref_go);
        end
    end

    assign w_ref_pend = r_ref_pend;
    assign ref_busy   = (r_state == S_REF_PREA)
                     || (r_state == S_REF_RP_WAIT)
                     || (r_state == S_REF)
                     || (r_state == S_REF_WAIT);
`else
    assign w_ref_pend = 1'b0;
    assign ref_busy   = 1'b0;
`endif

    assign w_ready    = (r_state == S_IDLE) && r_rdy_en && !w_ref_pend;
    assign w_hs       = req_valid && w_ready;
    assign w_req_idx  = {req_bg, req_ba};
    assign w_open     = r_valid[w_req_idx];
    assign w_hit      = w_open && (r_rows[w_req_idx] == req_row);
    assign w_any_open = |r_valid;

    // In IDLE the command is built from the live request, later from the latch.
    assign w_we  = (r_state == S_IDLE) ? req_we  : r_we;
    assign w_bg  = (r_state == S_IDLE) ? req_bg  : r_bg;
    assign w_ba  = (r_state == S_IDLE) ? req_ba  : r_ba;
    assign w_row = (r_state == S_IDLE) ? req_row : r_row;
    assign w_col = (r_state == S_IDLE) ? req_col : r_col;
    assign w_idx = {w_bg, w_ba};

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = (r_cnt != '0) ? r_cnt - TW'(1) : '0;
        unique case (r_state)
            S_IDLE: begin
                if (r_rdy_en && w_ref_pend) begin
                    w_nxt = w_any_open ? S_REF_PREA : S_REF;
                end else if (w_hs) begin
                    if (w_hit) begin
                        w_nxt = S_RW;
                    end else if (w_open) begin
                        w_nxt = S_PRE;
                    end else begin
                        w_nxt = S_ACT;
                    end
                end
            end
            S_PRE, S_PRE_WAIT:
                w_nxt = (r_cnt == '0) ? S_ACT : S_PRE_WAIT;
            S_ACT, S_ACT_WAIT:
                w_nxt = (r_cnt == '0) ? S_RW : S_ACT_WAIT;
            S_RW, S_RW_WAIT:
                w_nxt = (r_cnt == '0) ? S_IDLE : S_RW_WAIT;
            S_REF_PREA, S_REF_RP_WAIT:
                w_nxt = (r_cnt == '0) ? S_REF : S_REF_RP_WAIT;
            S_REF, S_REF_WAIT:
                w_nxt = (r_cnt == '0) ? S_IDLE : S_REF_WAIT;
            default:
                w_nxt = S_IDLE;
        endcase

        unique case (w_nxt)
            S_PRE:      w_cnt_nxt = L_TRP;
            S_ACT:      w_cnt_nxt = L_TRCD;
            S_RW:       w_cnt_nxt = L_TCCD;
            S_REF_PREA: w_cnt_nxt = L_TRP;
            S_REF:      w_cnt_nxt = L_TRFC;
            default:    ;
        endcase
    end

    // Command states are only ever entered, never held, so decode on w_nxt.
    always_comb begin
        w_cs_n  = 1'b1;
        w_act_n = 1'b1;
        w_a     = '0;
        w_bg_o  = '0;
        w_ba_o  = '0;
        unique case (w_nxt)
            S_PRE: begin
                w_cs_n     = 1'b0;
                w_a[16:14] = 3'b010;
                w_bg_o     = w_bg;
                w_ba_o     = w_ba;
            end
            S_ACT: begin
                w_cs_n  = 1'b0;
                w_act_n = 1'b0;
                w_a     = w_row;
                w_bg_o  = w_bg;
                w_ba_o  = w_ba;
            end
            S_RW: begin
                w_cs_n              = 1'b0;
                w_a[COLWIDTH-1:0]   = w_col;
                w_a[10]             = 1'b0;
                w_a[16:14]          = w_we ? 3'b100 : 3'b101;
                w_bg_o              = w_bg;
                w_ba_o              = w_ba;
            end
            S_REF_PREA: begin
                w_cs_n     = 1'b0;
                w_a[16:14] = 3'b010;
                w_a[10]    = 1'b1;
            end
            S_REF: begin
                w_cs_n     = 1'b0;
                w_a[16:14] = 3'b001;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cke       <= 1'b0;
            r_rdy_en    <= 1'b0;
            r_we        <= 1'b0;
            r_bg        <= '0;
            r_ba        <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_valid     <= '0;
            r_cs_n      <= 1'b1;
            r_act_n     <= 1'b1;
            r_a         <= '0;
            r_bg_o      <= '0;
            r_ba_o      <= '0;
            r_rw_issued <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cke       <= 1'b1;
            r_rdy_en    <= r_cke;
            r_cs_n      <= w_cs_n;
            r_act_n     <= w_act_n;
            r_a         <= w_a;
            r_bg_o      <= w_bg_o;
            r_ba_o      <= w_ba_o;
            r_rw_issued <= (w_nxt == S_RW);
            if (w_hs) begin
                r_we  <= req_we;
                r_bg  <= req_bg;
                r_ba  <= req_ba;
                r_row <= req_row;
                r_col <= req_col;
            end
            if (w_nxt == S_PRE) begin
                r_valid[w_idx] <= 1'b0;
            end else if (w_nxt == S_ACT) begin
                r_valid[w_idx] <= 1'b1;
            end
            if (r_state == S_REF_WAIT && w_nxt == S_IDLE) begin
                r_valid <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NB; i++) begin
                r_rows[i] <= '0;
            end
        end else if (w_nxt == S_ACT) begin
            r_rows[w_idx] <= w_row;
        end
    end

    assign req_ready = w_ready;
    assign cke       = r_cke;
    assign cs_n      = r_cs_n;
    assign act_n     = r_act_n;
    assign A         = r_a;
    assign bg        = r_bg_o;
    assign ba        = r_ba_o;
    assign rw_issued = r_rw_issued;

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Directed bench for ddr4_cmd_sequencer: table of request vectors with
// hand-computed command timelines, plus reset-abort and refresh sequences.
`timescale 1ns/1ps
module tb_ddr4_cmd_sequencer;

    localparam int TRP   = 4;
    localparam int TRCD  = 4;
    localparam int TCCD  = 4;
    localparam int TREFI = 100;
    localparam int TRFC  = 10;

    localparam int K_DES  = 0;
    localparam int K_PRE  = 1;
    localparam int K_ACT  = 2;
    localparam int K_RW   = 3;
    localparam int K_PREA = 4;
    localparam int K_REF  = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [16:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        cke;
    logic        cs_n;
    logic        act_n;
    logic [16:0] A;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic        ref_busy;
    logic        rw_issued;

    logic [23:0] obs;
    assign obs = {cs_n, act_n, A, bg, ba, rw_issued};

    int checks = 0;
    int failures = 0;
    int n_ref_cmds = 0;
    int n_busy = 0;

    typedef struct {
        logic        we;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [16:0] row;
        logic [9:0]  col;
        int          pre_at;
        int          act_at;
        int          rw_at;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    ddr4_cmd_sequencer #(
        .TRP(TRP), .TRCD(TRCD), .TCCD(TCCD), .TREFI(TREFI), .TRFC(TRFC)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .cke(cke), .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
        .ref_busy(ref_busy), .rw_issued(rw_issued)
    );

    always @(negedge clk) begin
        if (reset_n && !cs_n && act_n &&
            (A[16:14] == 3'b001 || (A[16:14] == 3'b010 && A[10])))
            n_ref_cmds++;
        if (ref_busy)
            n_busy++;
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [23:0] enc(input int kind, input vec_t v);
        logic        c;
        logic        an;
        logic [16:0] a;
        logic [1:0]  g;
        logic [1:0]  b;
        logic        rw;
        c = 1'b1; an = 1'b1; a = '0; g = '0; b = '0; rw = 1'b0;
        case (kind)
            K_PRE:  begin c = 0; a = 17'h08000; g = v.bg; b = v.ba; end
            K_ACT:  begin c = 0; an = 0; a = v.row; g = v.bg; b = v.ba; end
            K_RW: begin
                c = 0; g = v.bg; b = v.ba; rw = 1;
                a = (v.we ? 17'h10000 : 17'h14000) | {7'd0, v.col};
            end
            K_PREA: begin c = 0; a = 17'h08400; end
            K_REF:  begin c = 0; a = 17'h04000; end
            default: ;
        endcase
        return {c, an, a, g, b, rw};
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 60) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " ready wait"}, req_ready, 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int last;
        int kind;
        wait_ready(tag);
        if (!req_ready) return;
        req_valid = 1; req_we = v.we; req_bg = v.bg; req_ba = v.ba;
        req_row = v.row; req_col = v.col;
        @(posedge clk); #1;
        // keep offering junk while busy; it must be ignored
        req_we = ~v.we; req_bg = ~v.bg; req_ba = ~v.ba;
        req_row = v.row ^ 17'h00101; req_col = ~v.col;
        last = v.rw_at + TCCD;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == last) req_valid = 0;
            kind = (c == v.pre_at) ? K_PRE :
                   (c == v.act_at) ? K_ACT :
                   (c == v.rw_at)  ? K_RW  : K_DES;
            check($sformatf("%s c%0d cmd", tag, c), obs, enc(kind, v));
            check($sformatf("%s c%0d ready", tag, c), req_ready, c == last);
        end
    endtask

    task automatic do_reset();
        reset_n = 0; req_valid = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vr;
        vec_t des;
        int   n;
        vecs[0] = '{1'b0, 2'd1, 2'd2, 17'h01234, 10'h010, 0, 1, 5};
        vecs[1] = '{1'b0, 2'd1, 2'd2, 17'h01234, 10'h020, 0, 0, 1};
        vecs[2] = '{1'b1, 2'd1, 2'd2, 17'h00001, 10'h3FF, 1, 5, 9};
        vecs[3] = '{1'b1, 2'd1, 2'd2, 17'h00001, 10'h005, 0, 0, 1};
        vecs[4] = '{1'b0, 2'd0, 2'd0, 17'h1FFFF, 10'h000, 0, 1, 5};
        vecs[5] = '{1'b1, 2'd3, 2'd3, 17'h00000, 10'h3FF, 0, 1, 5};
        vecs[6] = '{1'b0, 2'd1, 2'd2, 17'h01234, 10'h2AA, 1, 5, 9};
        vecs[7] = '{1'b0, 2'd0, 2'd0, 17'h1FFFF, 10'h155, 0, 0, 1};
        vr  = '{1'b0, 2'd2, 2'd1, 17'h00ABC, 10'h055, 0, 1, 5};
        des = '{1'b0, 2'd0, 2'd0, 17'h0, 10'h0, 0, 0, 0};

        repeat (3) @(posedge clk); #1;
        check("reset outputs",
              {cke, cs_n, act_n, A, bg, ba, req_ready, ref_busy, rw_issued},
              {1'b0, 1'b1, 1'b1, 24'd0});
        reset_n = 1;
        @(posedge clk); #1;
        check("cke after release", cke, 1);
        check("ready lags cke", req_ready, 0);
        @(posedge clk); #1;
        check("ready after cke", req_ready, 1);

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        do_reset();
        wait_ready("abort pre");
        req_valid = 1; req_we = vr.we; req_bg = vr.bg; req_ba = vr.ba;
        req_row = vr.row; req_col = vr.col;
        @(posedge clk); #1;
        req_valid = 0;
        check("abort act", obs, enc(K_ACT, vr));
        @(posedge clk); #1;
        reset_n = 0;
        #1;
        check("abort immediate", {cke, cs_n, req_ready}, 3'b010);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("abort hold c%0d", c), {cke, obs}, {1'b0, enc(K_DES, des)});
        end
        reset_n = 1;
        run_vec(vr, "post-abort");

`ifdef REFRESH_EN
        do_reset();
        run_vec(vr, "ref open");
        n = 0;
        while (!ref_busy && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("ref busy seen", ref_busy, 1);
        check("prea cmd", obs, enc(K_PREA, des));
        for (int c = 1; c <= TRP + TRFC; c++) begin
            @(posedge clk); #1;
            check($sformatf("ref c%0d cmd", c), obs,
                  enc((c == TRP) ? K_REF : K_DES, des));
            check($sformatf("ref c%0d ready", c), req_ready, c == TRP + TRFC);
            check($sformatf("ref c%0d busy", c), ref_busy, c < TRP + TRFC);
        end
        run_vec(vr, "post-ref");
`else
        n = 0;
        repeat (120) @(posedge clk);
        #1;
        check("no refresh cmds", n_ref_cmds + n, 0);
        check("ref_busy never", n_busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
